// File: rtl/npu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | npu_pkg : shared widths, result type and saturation helper           |
// | rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
package npu_pkg;

    localparam int RESULT_W = 16;
    localparam int OUT_W    = 8;

    typedef logic [RESULT_W-1:0] res_t;

    function automatic logic [OUT_W-1:0] sat_u8(input logic [17:0] q);
        return (q > 18'd255) ? {OUT_W{1'b1}} : q[OUT_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/npu_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | npu_sync_fifo : synchronous FIFO, registered head, no fall-through   |
// | rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module npu_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty = (r_count == '0);
    assign full  = (r_count == CW'(DEPTH));
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    // A push into a full FIFO is legal when the head leaves on the same edge.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/npu_result_requant.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | npu_result_requant : bias, round-half-up shift, u8 saturate, FIFO    |
// | rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module npu_result_requant
    import npu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  res_t                         in_data,
    input  res_t                         bias,
    input  logic [3:0]                   shamt,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_W-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow,
    input  logic                         clr_ovf
);

    logic                  r_s1_valid;
    logic [RESULT_W:0]     r_s1_sum;
    logic [3:0]            r_s1_shamt;

    logic [17:0]           w_rnd;
    logic [17:0]           w_q;
    logic [OUT_W-1:0]      w_byte;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_empty;
    logic                  w_full;
    logic [OUT_W-1:0]      w_dout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sum   <= '0;
            r_s1_shamt <= '0;
        end else begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sum   <= {1'b0, in_data} + {1'b0, bias};
                r_s1_shamt <= shamt;
            end
        end
    end

    // 18 bits holds the worst case 0x1FFFE + 0x4000 without wrap.
    always_comb begin
        w_rnd  = (r_s1_shamt == 4'd0) ? 18'd0 : (18'd1 << (r_s1_shamt - 4'd1));
        w_q    = (18'(r_s1_sum) + w_rnd) >> r_s1_shamt;
        w_byte = sat_u8(w_q);
    end

    assign w_pop  = !w_empty && out_ready;
    assign w_push = r_s1_valid && (!w_full || w_pop);
    assign w_drop = r_s1_valid && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (w_drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    npu_sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (w_byte),
        .pop   (w_pop),
        .dout  (w_dout),
        .empty (w_empty),
        .full  (w_full),
        .count (level)
    );

    assign out_valid = !w_empty;
    assign out_data  = w_empty ? '0 : w_dout;

endmodule
`default_nettype wire

// File: tb/tb_npu_result_requant.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_npu_result_requant : directed + random bench with queue model     |
// | rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module tb_npu_result_requant;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic [15:0] bias = '0;
    logic [3:0]  shamt = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic [2:0]  level;
    logic        overflow;
    logic        clr_ovf = 1'b0;

    int total = 0;
    int bad   = 0;

    npu_result_requant #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .bias      (bias),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the rules, in plain integers.
    function automatic int requant(input int d, input int b, input int s);
        int sum;
        int r;
        int q;
        sum = d + b;
        r   = (s == 0) ? 0 : (1 << (s - 1));
        q   = (sum + r) >> s;
        return (q > 255) ? 255 : q;
    endfunction

    // Model: a byte captured in one cycle reaches the queue on the next edge.
    int  mq[$];
    bit  m_ovf  = 1'b0;
    bit  pend_v = 1'b0;
    int  pend_b = 0;
    bit  m_init = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_ovf  = 1'b0;
            pend_v = 1'b0;
            m_init = 1'b1;
        end else begin
            bit pop;
            bit drop;
            pop  = (mq.size() > 0) && out_ready;
            drop = pend_v && (mq.size() == DEPTH) && !pop;
            if (pop) void'(mq.pop_front());
            if (pend_v && !drop) mq.push_back(pend_b);
            if (drop) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
            pend_v = in_valid;
            pend_b = requant(int'(in_data), int'(bias), int'(shamt));
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            check("cmp_out_valid", int'(out_valid), (mq.size() > 0) ? 1 : 0);
            check("cmp_level", int'(level), mq.size());
            check("cmp_overflow", int'(overflow), int'(m_ovf));
            if (mq.size() > 0) check("cmp_out_data", int'(out_data), mq[0]);
        end
    end

    task automatic send_one(input int d, input int b, input int s, input int exp);
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'(d); bias = 16'(b); shamt = 4'(s);
        @(negedge clk);
        in_valid = 1'b0;
        check("lat_not_yet", int'(out_valid), 0);
        @(negedge clk);
        check("lat_valid", int'(out_valid), 1);
        check("lit_data", int'(out_data), exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("drained", int'(level), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_level", int'(level), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_overflow", int'(overflow), 0);
        rst = 1'b0;

        send_one(10, 0, 2, 3);
        send_one(1000, 24, 2, 255);
        send_one(16'hFFFF, 16'hFFFF, 15, 4);
        send_one(200, 0, 0, 200);
        send_one(256, 0, 0, 255);

        // Overflow: five results into a four-entry buffer with no drain.
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 16'(i); bias = '0; shamt = '0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("ovf_level", int'(level), 4);
        check("ovf_flag", int'(overflow), 1);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("ovf_order", int'(out_data), k);
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("ovf_empty", int'(level), 0);
        check("ovf_sticky", int'(overflow), 1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("ovf_cleared", int'(overflow), 0);

        // Full with a pop on the same edge as the push.
        for (int i = 10; i <= 14; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 16'(i); bias = '0; shamt = '0;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("fp_level_before", int'(level), 4);
        @(negedge clk);
        out_ready = 1'b0;
        check("fp_level_after", int'(level), 4);
        check("fp_no_ovf", int'(overflow), 0);
        out_ready = 1'b1;
        for (int k = 11; k <= 14; k++) begin
            check("fp_order", int'(out_data), k);
            @(negedge clk);
        end
        out_ready = 1'b0;

        // Reset mid-stream, with an in_valid in the reset cycle.
        for (int i = 30; i <= 32; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 16'(i); bias = '0; shamt = '0;
        end
        @(negedge clk);
        in_data = 16'd77;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        check("rst_mid_valid", int'(out_valid), 0);
        check("rst_mid_level", int'(level), 0);
        send_one(50, 0, 0, 50);

        // Random traffic; the model comparison runs on every cycle.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 1023));
            bias      = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
            shamt     = 4'($urandom_range(0, 15));
            out_ready = (c < 1500) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
            clr_ovf   = ($urandom_range(0, 19) == 0);
            rst       = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b0; clr_ovf = 1'b0; out_ready = 1'b1;
        repeat (8) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
